// File: rtl/fifo_arb_rx.sv
// fifo_arb_rx: pulls header-framed packets from an upstream FIFO and routes
// each packet whole to one of two client FIFOs. The header selects the client
// and carries the payload count. A one-entry skid absorbs the single byte that
// can still be in flight when the destination fills.

// Single-clock FIFO with a registered read port. rd_data is valid the cycle
// after rd_en is accepted. rst flushes the pointers.
module fifo #(
  parameter int DEPTH_WIDTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH:0]   wptr, rptr;

  // The extra pointer bit tells full apart from empty when the low bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_WIDTH] != rptr[DEPTH_WIDTH]) &&
                 (wptr[DEPTH_WIDTH-1:0] == rptr[DEPTH_WIDTH-1:0]);

  // Storage array; it is never reset, since the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wptr[DEPTH_WIDTH-1:0]] <= wr_data;
  end

  // Pointer update and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + 1'b1;
      if (rd_en && !empty) begin
        rd_data <= mem[rptr[DEPTH_WIDTH-1:0]];
        rptr    <= rptr + 1'b1;
      end
    end
  end
endmodule

module fifo_arb_rx #(
  parameter int               DWIDTH  = 8,
  parameter int               AWIDTH  = 3,
  parameter logic [DWIDTH-1:0] SELMASK = 8'h80,
  parameter logic [DWIDTH-1:0] CNTMASK = 8'h70
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fifo_rdempty,
  output logic              fifo_rden,
  input  logic [DWIDTH-1:0] fifo_rddata,
  input  logic              c1_rden,
  output logic [DWIDTH-1:0] c1_rddata,
  output logic              c1_rdempty,
  input  logic              c2_rden,
  output logic [DWIDTH-1:0] c2_rddata,
  output logic              c2_rdempty
);
  localparam int NCLI = 2;

  // Bit position of the lowest set bit of the count field.
  function automatic int lsb_idx(input logic [DWIDTH-1:0] m);
    int r;
    r = 0;
    for (int i = DWIDTH - 1; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  localparam int CNT_SH = lsb_idx(CNTMASK);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t state, state_nx;

  // Client FIFO ports. Index 0 is client 1 and index 1 is client 2.
  logic [NCLI-1:0]             cl_wr, cl_full, cl_rd, cl_empty;
  logic [NCLI-1:0][DWIDTH-1:0] cl_rdata;
  logic [DWIDTH-1:0]           wr_data;

  logic [2:0]        issue_cnt, arr_cnt;   // reads left to issue, bytes left to arrive
  logic              dest_r;               // 0 = client 1, 1 = client 2
  logic              rd_pend;              // upstream data valid this cycle
  logic              skid_vld;
  logic [DWIDTH-1:0] skid_data;

  logic              hdr_dest, cur_dest, rd_issue;
  logic [2:0]        hdr_n;
  logic              skid_set, skid_clr;

  genvar g;
  generate
    for (g = 0; g < NCLI; g++) begin : g_cli
      fifo #(.DEPTH_WIDTH(AWIDTH), .DATA_WIDTH(DWIDTH)) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (cl_wr[g]),
        .wr_data (wr_data),
        .full    (cl_full[g]),
        .rd_en   (cl_rd[g]),
        .rd_data (cl_rdata[g]),
        .empty   (cl_empty[g])
      );
    end
  endgenerate

  assign cl_rd      = {c2_rden, c1_rden};
  assign c1_rddata  = cl_rdata[0];
  assign c2_rddata  = cl_rdata[1];
  assign c1_rdempty = cl_empty[0];
  assign c2_rdempty = cl_empty[1];

  // Header decode. It is only meaningful in HDR, when the header is on fifo_rddata.
  assign hdr_dest = ((fifo_rddata & SELMASK) == SELMASK) ? 1'b0 : 1'b1;
  assign hdr_n    = 3'((fifo_rddata & CNTMASK) >> CNT_SH);
  assign cur_dest = (state == HDR) ? hdr_dest : dest_r;

  // The read strobe is forced low while reset is held, whatever the upstream level.
  assign fifo_rden = rd_issue && !RESET;

  // Next-state logic and the upstream read decision.
  always_comb begin
    state_nx = state;
    rd_issue = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_rdempty && !skid_vld) begin
          rd_issue = 1'b1;
          state_nx = HDR;
        end
      end
      HDR: begin
        // No read in this cycle: the header is being decoded.
        state_nx = (hdr_n == 3'd0) ? IDLE : PAY;
      end
      PAY: begin
        if (!fifo_rdempty && (issue_cnt != 3'd0) && !skid_vld && !cl_full[dest_r])
          rd_issue = 1'b1;
        if ((arr_cnt == 3'd0) && !skid_vld) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Client write steering. A full skid always drains before a new arrival is written.
  // A byte cannot arrive while the skid is full, because a read is issued only when
  // the skid is empty and the destination is not full.
  always_comb begin
    cl_wr    = '0;
    wr_data  = skid_data;
    skid_set = 1'b0;
    skid_clr = 1'b0;
    if (skid_vld) begin
      if (!cl_full[dest_r]) begin
        cl_wr[dest_r] = 1'b1;
        skid_clr      = 1'b1;
      end
    end else if (rd_pend) begin
      if (!cl_full[cur_dest]) begin
        cl_wr[cur_dest] = 1'b1;
        wr_data         = fifo_rddata;
      end else begin
        skid_set = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Arrival tracking and the skid register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_pend   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else begin
      rd_pend <= fifo_rden;
      if (skid_set) begin
        skid_vld  <= 1'b1;
        skid_data <= fifo_rddata;
      end else if (skid_clr) begin
        skid_vld <= 1'b0;
      end
    end
  end

  // Packet context: destination plus the issue and arrival countdowns.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dest_r    <= 1'b0;
      issue_cnt <= '0;
      arr_cnt   <= '0;
    end else begin
      case (state)
        HDR: begin
          dest_r    <= hdr_dest;
          issue_cnt <= hdr_n;
          arr_cnt   <= hdr_n;
        end
        PAY: begin
          if (rd_issue) issue_cnt <= issue_cnt - 3'd1;
          if (rd_pend)  arr_cnt   <= arr_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_arb_rx.sv
// Scoreboard bench for fifo_arb_rx. The stimulus loads an upstream FIFO model
// and pushes the expected client bytes. A monitor drains both clients and
// compares each byte read against the expected queue for that client.
module tb_fifo_arb_rx;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       fifo_rdempty, fifo_rden;
  logic [7:0] fifo_rddata;
  logic       c1_rden = 1'b0, c2_rden = 1'b0;
  logic [7:0] c1_rddata, c2_rddata;
  logic       c1_rdempty, c2_rdempty;

  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  fifo_arb_rx dut (
    .CLK(CLK), .RESET(RESET),
    .fifo_rdempty(fifo_rdempty), .fifo_rden(fifo_rden), .fifo_rddata(fifo_rddata),
    .c1_rden(c1_rden), .c1_rddata(c1_rddata), .c1_rdempty(c1_rdempty),
    .c2_rden(c2_rden), .c2_rddata(c2_rddata), .c2_rdempty(c2_rdempty)
  );

  // Upstream FIFO model. Data is valid the cycle after a strobe.
  logic [7:0] up_mem [256];
  int wptr = 0, rptr = 0, cyc = 0, bad_rd = 0;
  int rden_log[$];
  assign fifo_rdempty = (rptr == wptr);

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (fifo_rden) begin
      rden_log.push_back(cyc);
      if (rptr == wptr) bad_rd <= bad_rd + 1;
      else begin
        fifo_rddata <= up_mem[rptr % 256];
        rptr <= rptr + 1;
      end
    end
  end

  logic [7:0] exp_c1[$], exp_c2[$];
  logic c1_en = 1'b0, c2_en = 1'b0, p1 = 1'b0, p2 = 1'b0;
  int c2_got = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Monitor: compare bytes whose read was issued on the previous cycle, then issue new reads.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (p1) begin
        checks++;
        if (exp_c1.size() == 0) begin
          errors++;
          $display("FAIL c1_data: got 0x%0h expected no byte", c1_rddata);
        end else begin
          e = exp_c1.pop_front();
          if (c1_rddata !== e) begin
            errors++;
            $display("FAIL c1_data: got 0x%0h expected 0x%0h", c1_rddata, e);
          end
        end
      end
      if (p2) begin
        c2_got++;
        checks++;
        if (exp_c2.size() == 0) begin
          errors++;
          $display("FAIL c2_data: got 0x%0h expected no byte", c2_rddata);
        end else begin
          e = exp_c2.pop_front();
          if (c2_rddata !== e) begin
            errors++;
            $display("FAIL c2_data: got 0x%0h expected 0x%0h", c2_rddata, e);
          end
        end
      end
      p1 = c1_en && !c1_rdempty && !RESET;
      p2 = c2_en && !c2_rdempty && !RESET;
      c1_rden = p1;
      c2_rden = p2;
    end
  end

  task automatic up(input logic [7:0] b);
    up_mem[wptr % 256] = b;
    wptr++;
  endtask

  task automatic pkt(input int cl, input logic [7:0] b);
    up(b);
    if (cl == 1) exp_c1.push_back(b);
    else         exp_c2.push_back(b);
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK); #1;
      done = (exp_c1.size() == 0) && (exp_c2.size() == 0) && (rptr == wptr) && !p1 && !p2;
    end
    chk(nm, int'(done), 1);
  endtask

  initial begin
    int base, c2b;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_rden", int'(fifo_rden), 0);
    chk("rst_c1_empty", int'(c1_rdempty), 1);
    chk("rst_c2_empty", int'(c2_rdempty), 1);
    @(negedge CLK); RESET = 1'b0;
    #1; c1_en = 1'b1; c2_en = 1'b1;

    // Header-only packet to client 1.
    pkt(1, 8'h80);
    drain("t027_drain");
    repeat (5) @(negedge CLK);
    chk("t027_c2_empty", int'(c2_rdempty), 1);
    chk("t027_c2_count", c2_got, 0);

    // Client 2 packet: one bubble after the header, then back-to-back payload reads.
    base = rden_log.size();
    pkt(2, 8'h30); pkt(2, 8'hAA); pkt(2, 8'hBB); pkt(2, 8'hCC);
    drain("t028_drain");
    chk("t028_nreads", rden_log.size() - base, 4);
    if (rden_log.size() - base == 4) begin
      chk("t028_bubble", rden_log[base+1] - rden_log[base], 2);
      chk("t028_pay1", rden_log[base+2] - rden_log[base+1], 1);
      chk("t028_pay2", rden_log[base+3] - rden_log[base+2], 1);
    end

    // A payload byte of 0x80 must not be decoded as a header.
    pkt(1, 8'h90); pkt(1, 8'h80); pkt(2, 8'h10); pkt(2, 8'h55);
    drain("t029_drain");

    // Client 1 holds 7 entries; then a packet of 8 bytes stalls once client 1 is full.
    #1; c1_en = 1'b0;
    pkt(1, 8'hE0);
    for (int i = 1; i <= 6; i++) pkt(1, 8'(i));
    pkt(1, 8'hF0);
    for (int i = 0; i < 7; i++) pkt(1, 8'(8'h11 + i));
    repeat (30) @(negedge CLK);
    #1;
    chk("t030_up_left", wptr - rptr, 7);
    base = rden_log.size();
    repeat (20) @(negedge CLK);
    chk("t030_stall", rden_log.size() - base, 0);
    chk("t030_c1_nonempty", int'(c1_rdempty), 0);
    #1; c1_en = 1'b1;
    drain("t030_drain");

    // Head-of-line blocking: the client 2 packet waits behind the blocked client 1 packet.
    #1; c1_en = 1'b0;
    c2b = c2_got;
    pkt(1, 8'hF0);
    for (int i = 0; i < 7; i++) pkt(1, 8'(8'h21 + i));
    pkt(1, 8'h90); pkt(1, 8'h31);
    pkt(2, 8'h20); pkt(2, 8'h41); pkt(2, 8'h42);
    repeat (40) @(negedge CLK);
    #1;
    chk("t031_c2_blocked", c2_got - c2b, 0);
    chk("t031_up_left", wptr - rptr, 4);
    chk("t031_c2_empty", int'(c2_rdempty), 1);
    #1; c1_en = 1'b1;
    drain("t031_drain");

    // Reset in the middle of the payload. Header 0x50 and byte 01 have been read,
    // so 02..05 remain upstream and each is taken as a header-only client 2 packet.
    #1; c2_en = 1'b0;
    up(8'h50);
    for (int i = 1; i <= 5; i++) up(8'(i));
    @(posedge CLK); @(posedge CLK); @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("t032_rden", int'(fifo_rden), 0);
    chk("t032_c1_empty", int'(c1_rdempty), 1);
    chk("t032_c2_empty", int'(c2_rdempty), 1);
    chk("t032_up_left", wptr - rptr, 4);
    repeat (2) @(negedge CLK);
    for (int i = 2; i <= 5; i++) exp_c2.push_back(8'(i));
    RESET = 1'b0;
    #1; c2_en = 1'b1;
    drain("t032_drain");
    pkt(1, 8'h85);
    drain("t032_after");

    chk("no_empty_reads", bad_rd, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_arb_rx.md
FIFO_ARB_RX -- requirements
Module: fifo_arb_rx

Interface
REQ-001 SHALL have parameter SELMASK, default 8'h80: header bits that, when all set in the header, route the packet to client 1; otherwise the packet goes to client 2.
REQ-002 SHALL have parameter CNTMASK, default 8'h70: contiguous 3-bit payload-count field within the header.
REQ-003 SHALL have parameter DWIDTH, default 8: data width.
REQ-004 SHALL have parameter AWIDTH, default 3: address width of each internal client FIFO (depth 2**AWIDTH).
REQ-005 SHALL have ports: CLK  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have ports: RESET  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports: fifo_rdempty  in  1  upstream FIFO empty.
REQ-008 SHALL have ports: fifo_rden  out  1  upstream FIFO read strobe.
REQ-009 SHALL have ports: fifo_rddata  in  DWIDTH  upstream data, valid the cycle after fifo_rden.
REQ-010 SHALL have ports: c1_rden  in  1 / c1_rddata  out  DWIDTH / c1_rdempty  out  1  client 1 FIFO read side.
REQ-011 SHALL have ports: c2_rden  in  1 / c2_rddata  out  DWIDTH / c2_rdempty  out  1  client 2 FIFO read side.

Function
REQ-012 SHALL instantiate one codebase fifo per client (DEPTH_WIDTH=AWIDTH, DATA_WIDTH=DWIDTH, rst=RESET); clients read it directly.
REQ-013 SHALL decode the header as follows:
- dest = c1 when (hdr & SELMASK) == SELMASK, else c2;
- N = (hdr & CNTMASK) >> (bit index of lowest set bit of CNTMASK), range 0..7;
- packet = header + N payload bytes.
REQ-014 SHALL forward the header and all payload bytes unmodified and in order to dest; no byte dropped or duplicated.
REQ-015 SHALL run an FSM with states IDLE, HDR, PAY:
- IDLE: assert fifo_rden when ~fifo_rdempty and skid empty, then -> HDR.
- HDR: header arrives and is decoded; -> IDLE if N==0, else -> PAY with issue and arrival counters = N.
- PAY: -> IDLE once the N-th payload byte is written to dest and skid is empty.
REQ-016 SHALL, in PAY, assert fifo_rden only when all hold: ~fifo_rdempty, issue counter > 0, skid empty, dest FIFO not full; decrement issue counter per strobe.
REQ-017 SHALL issue no upstream read in HDR; the header decode costs exactly one bubble cycle.
REQ-018 SHALL sustain one payload byte per cycle when upstream is non-empty and dest not full.
REQ-019 SHALL write an arriving byte to dest in its arrival cycle when dest is not full; otherwise capture it in a one-entry skid register.
REQ-020 SHALL drain the skid to dest the first cycle dest is not full; the skid drains before any later byte is written.
REQ-021 SHALL block on the current packet while dest is full even if the other client has space (strict packet order, head-of-line blocking).
REQ-022 SHALL never treat payload bytes as headers, regardless of value.
REQ-023 SHALL never write a full client FIFO and never read an empty upstream FIFO.
REQ-024 SHALL apply the N==0 case identically for c1 and c2 (header-only packet).

Reset
REQ-025 SHALL, while RESET is high (asynchronously):
- FSM = IDLE; counters = 0; skid empty; fifo_rden = 0;
- c1_rdempty = 1, c2_rdempty = 1 (internal FIFOs flushed).
REQ-026 SHALL discard any partial packet on reset; the first byte read after RESET deasserts is treated as a header.

Verification
REQ-027 Header 0x80 alone -> c1 receives 0x80 only; c2_rdempty stays 1; FSM returns to IDLE.
REQ-028 0x30, AA, BB, CC -> c2 receives 30, AA, BB, CC in order; payload reads on consecutive cycles after the one-cycle header bubble.
REQ-029 0x90, 80, 0x10, 55 -> c1 gets 90, 80; c2 gets 10, 55; payload 0x80 is not decoded as a header.
REQ-030 c1 FIFO pre-filled to 7/8, client idle, then 0xF0 + 7 bytes:
- fifo_rden stalls with no overflow;
- after c1_rden is pulsed one per cycle, all 8 bytes arrive in order.
REQ-031 c1 full and blocked, with a c1 packet followed by a c2 packet queued upstream -> the c2 packet is not delivered until the c1 packet completes.
REQ-032 RESET asserted mid-PAY of 0x50 packet -> fifo_rden = 0 and both rdempty = 1 immediately; next byte after release is routed as a header.
